// File: rtl/bootprom_ctrl.sv
// Boot EPROM bus controller: 68010 PROM-space cycles to 27256 strobes, word merge, DTACK/BERR.
// Optional BOOTPROM_OVERLAY_EN maps reads at any address to PROM for the first four reads after reset.
module bootprom_ctrl #(
    parameter int unsigned ACCESS_CYCLES   = 4,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic [23:1] cpu_addr,
    input  logic        prom_sel,
    output logic [15:0] cpu_data_out,
    output logic        cpu_data_oe,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic [14:0] prom_addr,
    output logic        prom_ce_n,
    output logic        prom_oe_n,
    input  logic [7:0]  prom_data_h,
    input  logic [7:0]  prom_data_l
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        HOLD,
        ERR,
        RECOVER
    } state_t;

    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] REC_LOAD =
        (RECOVERY_CYCLES == 0) ? 4'd0 : 4'(RECOVERY_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       rd_hit;
    logic       wr_hit;
    logic       unused_addr;

    assign unused_addr = ^cpu_addr[23:16];

`ifdef BOOTPROM_OVERLAY_EN
    logic       ovl;
    logic [1:0] rd_cnt;

    // Reads reaching HOLD are counted; the fourth one drops the overlay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovl    <= 1'b1;
            rd_cnt <= 2'd0;
        end else if (ovl && state == ACCESS && !cpu_as_n && cnt == 4'd0) begin
            rd_cnt <= rd_cnt + 2'd1;
            if (rd_cnt == 2'd3)
                ovl <= 1'b0;
        end
    end

    assign rd_hit = !cpu_as_n && cpu_rw && (prom_sel || ovl);
    assign wr_hit = !cpu_as_n && !cpu_rw && prom_sel;
`else
    assign rd_hit = !cpu_as_n && cpu_rw && prom_sel;
    assign wr_hit = !cpu_as_n && !cpu_rw && prom_sel;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cpu_data_out <= 16'd0;
            cpu_data_oe  <= 1'b0;
            cpu_dtack_n  <= 1'b1;
            cpu_berr_n   <= 1'b1;
            prom_addr    <= 15'd0;
            prom_ce_n    <= 1'b1;
            prom_oe_n    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_hit) begin
                        state     <= ACCESS;
                        prom_addr <= cpu_addr[15:1];
                        cnt       <= ACC_LOAD;
                        prom_ce_n <= 1'b0;
                        prom_oe_n <= 1'b0;
                    end else if (wr_hit) begin
                        state      <= ERR;
                        cpu_berr_n <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cpu_as_n) begin
                        state     <= RECOVER;
                        cnt       <= REC_LOAD;
                        prom_ce_n <= 1'b1;
                        prom_oe_n <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        cpu_data_out <= {prom_data_h, prom_data_l};
                        state        <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cpu_as_n) begin
                        state       <= RECOVER;
                        cnt         <= REC_LOAD;
                        cpu_dtack_n <= 1'b1;
                        cpu_data_oe <= 1'b0;
                        prom_ce_n   <= 1'b1;
                        prom_oe_n   <= 1'b1;
                    end else begin
                        cpu_dtack_n <= 1'b0;
                        cpu_data_oe <= 1'b1;
                    end
                end
                ERR: begin
                    if (cpu_as_n) begin
                        state      <= RECOVER;
                        cnt        <= REC_LOAD;
                        cpu_berr_n <= 1'b1;
                    end
                end
                RECOVER: begin
                    cpu_dtack_n <= 1'b1;
                    cpu_berr_n  <= 1'b1;
                    cpu_data_oe <= 1'b0;
                    prom_ce_n   <= 1'b1;
                    prom_oe_n   <= 1'b1;
                    if (cnt == 4'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bootprom_ctrl.sv
// Bench for bootprom_ctrl: vector table, corner sequences, random bus cycles vs a transaction model.
// Build with BOOTPROM_OVERLAY_EN defined to exercise the reset overlay.
module tb_bootprom_ctrl;

    localparam int AC      = 4;
    localparam int RC      = 1;
    localparam int REC_EFF = (RC == 0) ? 1 : RC;
    localparam int MAXW    = AC + 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_as_n = 1'b1;
    logic        cpu_rw = 1'b1;
    logic [23:1] cpu_addr = '0;
    logic        prom_sel = 1'b0;
    logic [15:0] cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;
    logic [14:0] prom_addr;
    logic        prom_ce_n;
    logic        prom_oe_n;
    logic [7:0]  prom_data_h;
    logic [7:0]  prom_data_l;

    int n_chk  = 0;
    int n_fail = 0;
    int lowcnt = 0;

    always #5 clk = ~clk;

    bootprom_ctrl #(.ACCESS_CYCLES(AC), .RECOVERY_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .prom_sel(prom_sel), .cpu_data_out(cpu_data_out),
        .cpu_data_oe(cpu_data_oe), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
        .prom_addr(prom_addr), .prom_ce_n(prom_ce_n), .prom_oe_n(prom_oe_n),
        .prom_data_h(prom_data_h), .prom_data_l(prom_data_l)
    );

    function automatic logic [15:0] prom_word(input logic [14:0] a);
        return {a[7:0] ^ 8'hA4, a[7:0] ^ 8'h3D};
    endfunction

    // EPROM model: outputs garbage until enabled for the access time.
    logic [15:0] pw;
    assign pw = prom_word(prom_addr);
    assign prom_data_h = (!prom_oe_n && lowcnt >= AC - 1) ? pw[15:8] : 8'hEE;
    assign prom_data_l = (!prom_oe_n && lowcnt >= AC - 1) ? pw[7:0] : 8'hEE;
    always @(posedge clk) lowcnt <= prom_ce_n ? 0 : lowcnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("dtack_berr_excl", 32'(cpu_dtack_n | cpu_berr_n), 32'd1);
            check("oe_eq_ce", 32'(prom_oe_n), 32'(prom_ce_n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input logic rw, input logic sel, input logic [23:0] baddr,
                             input int abort_j, input int hold_extra,
                             output int resp, output int lat, output logic ce_seen,
                             output logic [15:0] dout, output logic [14:0] paddr,
                             output logic rel_ok);
        resp = 0; lat = -1; ce_seen = 1'b0; rel_ok = 1'b1;
        cpu_rw = rw; prom_sel = sel; cpu_addr = baddr[23:1]; cpu_as_n = 1'b0;
        for (int i = 0; i < MAXW; i++) begin
            tick();
            if (!prom_ce_n) ce_seen = 1'b1;
            if (!cpu_dtack_n) begin resp = 1; lat = i; break; end
            if (!cpu_berr_n) begin resp = 2; lat = i; break; end
            if (i == abort_j) break;
        end
        dout = cpu_data_out;
        paddr = prom_addr;
        if (resp != 0)
            for (int k = 0; k < hold_extra; k++) begin
                tick();
                if (cpu_dtack_n && cpu_berr_n) rel_ok = 1'b0;
            end
        cpu_as_n = 1'b1;
        prom_sel = 1'b0;
        tick();
        if (!cpu_dtack_n || !cpu_berr_n || !prom_ce_n || cpu_data_oe) rel_ok = 1'b0;
        for (int k = 0; k < REC_EFF; k++) tick();
    endtask

    // Transaction-level reference state.
    logic        ovl_m;
    int          rdcnt_m;
    logic [15:0] data_m;
    logic [14:0] paddr_m;

    task automatic model_reset();
        data_m = '0; paddr_m = '0; rdcnt_m = 0;
`ifdef BOOTPROM_OVERLAY_EN
        ovl_m = 1'b1;
`else
        ovl_m = 1'b0;
`endif
    endtask

    task automatic txn(input string name, input logic rw, input logic sel,
                       input logic [23:0] baddr, input int abort_j, input int hold_extra,
                       output int resp, output logic [15:0] dout, output logic [14:0] paddr);
        logic hit_rd, hit_wr, ce_seen, rel_ok;
        int exp_resp, exp_lat, lat;
        hit_rd = rw && (sel || ovl_m);
        hit_wr = !rw && sel;
        exp_resp = (hit_rd && abort_j >= 0) ? 0 : hit_rd ? 1 : hit_wr ? 2 : 0;
        exp_lat = (exp_resp == 1) ? AC + 1 : (exp_resp == 2) ? 0 : -1;
        if (hit_rd) paddr_m = baddr[15:1];
        if (exp_resp == 1) begin
            data_m = prom_word(baddr[15:1]);
            if (ovl_m) begin
                rdcnt_m++;
                if (rdcnt_m == 4) ovl_m = 1'b0;
            end
        end
        run_cycle(rw, sel, baddr, abort_j, hold_extra, resp, lat, ce_seen, dout, paddr, rel_ok);
        check({name, "_resp"}, 32'(resp), 32'(exp_resp));
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_ce"}, 32'(ce_seen), 32'(hit_rd));
        check({name, "_data"}, 32'(dout), 32'(data_m));
        check({name, "_paddr"}, 32'(paddr), 32'(paddr_m));
        check({name, "_release"}, 32'(rel_ok), 32'd1);
    endtask

    task automatic wait_dtack(output int edges);
        edges = -1;
        for (int i = 0; i < MAXW; i++) begin
            tick();
            if (!cpu_dtack_n) begin edges = i; break; end
        end
    endtask

    typedef struct {
        logic        rw;
        logic        sel;
        logic [23:0] baddr;
        int          abort_j;
        int          exp_resp;
        logic [15:0] exp_data;
        logic [14:0] exp_paddr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int resp, edges, hi_cnt;
        logic [15:0] dout;
        logic [14:0] paddr;
        logic [31:0] r;

        vecs[0] = '{1'b1, 1'b1, 24'h0F0002, -1, 1, 16'hA53C, 15'h0001};
        vecs[1] = '{1'b0, 1'b1, 24'h0F0010, -1, 2, 16'hA53C, 15'h0001};
        vecs[2] = '{1'b1, 1'b1, 24'h000100, -1, 1, 16'h24BD, 15'h0080};
        vecs[3] = '{1'b1, 1'b0, 24'h0F0004, -1, 0, 16'h24BD, 15'h0080};
        vecs[4] = '{1'b0, 1'b0, 24'h0F0006, -1, 0, 16'h24BD, 15'h0080};
        vecs[5] = '{1'b1, 1'b1, 24'h000040, 1, 0, 16'h24BD, 15'h0020};
        vecs[6] = '{1'b1, 1'b1, 24'h00FFFE, -1, 1, 16'h5BC2, 15'h7FFF};
        vecs[7] = '{1'b1, 1'b1, 24'hFF0000, -1, 1, 16'hA43D, 15'h0000};
        vecs[8] = '{1'b1, 1'b1, 24'h000040, AC - 1, 0, 16'hA43D, 15'h0020};

        model_reset();
        repeat (3) tick();
        check("rst_dtack", 32'(cpu_dtack_n), 32'd1);
        check("rst_berr", 32'(cpu_berr_n), 32'd1);
        check("rst_ce", 32'(prom_ce_n), 32'd1);
        check("rst_oe", 32'(prom_oe_n), 32'd1);
        check("rst_data_oe", 32'(cpu_data_oe), 32'd0);
        check("rst_data", 32'(cpu_data_out), 32'd0);
        check("rst_paddr", 32'(prom_addr), 32'd0);
        reset_n = 1'b1;
        tick();

`ifdef BOOTPROM_OVERLAY_EN
        for (int k = 0; k < 4; k++) begin
            txn("ovl_rd", 1'b1, 1'b0, 24'(k * 2), -1, 0, resp, dout, paddr);
            check("ovl_resp", 32'(resp), 32'd1);
            check("ovl_word", 32'(dout), 32'(prom_word(15'(k))));
        end
        txn("ovl_5th", 1'b1, 1'b0, 24'h000008, -1, 0, resp, dout, paddr);
        check("ovl_5th_none", 32'(resp), 32'd0);
`endif

        foreach (vecs[i]) begin
            txn("vec", vecs[i].rw, vecs[i].sel, vecs[i].baddr, vecs[i].abort_j,
                1, resp, dout, paddr);
            check("vec_resp_tbl", 32'(resp), 32'(vecs[i].exp_resp));
            check("vec_data_tbl", 32'(dout), 32'(vecs[i].exp_data));
            check("vec_paddr_tbl", 32'(paddr), 32'(vecs[i].exp_paddr));
        end

        // Back-to-back: AS re-asserted right after the HOLD release edge.
        cpu_rw = 1'b1; prom_sel = 1'b1; cpu_addr = 23'h000010; cpu_as_n = 1'b0;
        wait_dtack(edges);
        check("b2b_first_lat", 32'(edges), 32'(AC + 1));
        cpu_as_n = 1'b1;
        tick();
        check("b2b_ce_rel", 32'(prom_ce_n), 32'd1);
        cpu_addr = 23'h000011; cpu_as_n = 1'b0;
        hi_cnt = 1;
        for (int i = 0; i < MAXW; i++) begin
            tick();
            if (!prom_ce_n) break;
            hi_cnt++;
        end
        check("b2b_ce_gap", 32'(hi_cnt), 32'(REC_EFF + 1));
        wait_dtack(edges);
        check("b2b_second_resp", 32'(edges >= 0), 32'd1);
        check("b2b_second_data", 32'(cpu_data_out), 32'(prom_word(15'h0011)));
        data_m = prom_word(15'h0011);
        paddr_m = 15'h0011;
        cpu_as_n = 1'b1; prom_sel = 1'b0;
        repeat (REC_EFF + 1) tick();

        // Reset pulse while the read is in HOLD.
        cpu_rw = 1'b1; prom_sel = 1'b1; cpu_addr = 23'h000005; cpu_as_n = 1'b0;
        wait_dtack(edges);
        check("hold_rst_pre", 32'(edges), 32'(AC + 1));
        #2 reset_n = 1'b0;
        #1;
        check("hold_rst_dtack", 32'(cpu_dtack_n), 32'd1);
        check("hold_rst_ce", 32'(prom_ce_n), 32'd1);
        check("hold_rst_data", 32'(cpu_data_out), 32'd0);
        check("hold_rst_data_oe", 32'(cpu_data_oe), 32'd0);
        #2 reset_n = 1'b1;
        cpu_as_n = 1'b1; prom_sel = 1'b0;
        model_reset();
        repeat (2) tick();
        txn("post_rst", 1'b1, 1'b1, 24'h000200, -1, 0, resp, dout, paddr);

        for (int n = 0; n < 40; n++) begin
            logic rw, sel;
            int abort_j, hold_extra;
            repeat ($urandom_range(0, 2)) tick();
            r = $urandom();
            rw = ($urandom_range(0, 3) != 0);
            sel = ($urandom_range(0, 3) != 0);
            abort_j = (rw && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, AC - 1)) : -1;
            hold_extra = int'($urandom_range(0, 3));
            txn("rnd", rw, sel, {r[23:1], 1'b0}, abort_j, hold_extra, resp, dout, paddr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
